// File: rtl/apu_mixer_pkg.sv
// Shared types and helpers for the APU stereo mixer: frame phase encoding and
// the DAC code-to-signed conversion.
package apu_mixer_pkg;

    typedef enum logic [2:0] {
        PH_LATCH = 3'd0,
        PH_CH1   = 3'd1,
        PH_CH2   = 3'd2,
        PH_CH3   = 3'd3,
        PH_CH4   = 3'd4,
        PH_VIN   = 3'd5,
        PH_SCALE = 3'd6,
        PH_OUT   = 3'd7
    } mix_phase_t;

    // Unsigned 4-bit DAC code to a symmetric signed level (-15..+15); unpowered DAC gives 0.
    function automatic logic signed [5:0] dac_signed(input logic [3:0] code, input logic en);
        logic signed [5:0] s;
        if (en) begin
            s = $signed({1'b0, code, 1'b0}) - 6'sd15;
        end else begin
            s = 6'sd0;
        end
        return s;
    endfunction

endpackage

// File: rtl/apu_mixer_if.sv
// Signal bundle between the sound-control/channel side and the mixer:
// channel codes, routing, volumes in; stereo sample pair, strobe and phase out.
interface apu_mixer_if #(
    parameter int CODE_W = 4,
    parameter int OUT_W  = 11
);
    logic [CODE_W-1:0]       ch1_out;
    logic [CODE_W-1:0]       ch2_out;
    logic [CODE_W-1:0]       ch3_out;
    logic [CODE_W-1:0]       ch4_out;
    logic [3:0]              ch_dac_en;
    logic [CODE_W-1:0]       vin;
    logic                    vin_l_ena;
    logic                    vin_r_ena;
    logic [3:0]              lmixer;
    logic [3:0]              rmixer;
    logic [2:0]              nlvolume;
    logic [2:0]              nrvolume;
    logic signed [OUT_W-1:0] sample_l;
    logic signed [OUT_W-1:0] sample_r;
    logic                    sample_valid;
    logic [2:0]              mix_phase;

    modport master (
        output ch1_out, ch2_out, ch3_out, ch4_out, ch_dac_en, vin,
        output vin_l_ena, vin_r_ena, lmixer, rmixer, nlvolume, nrvolume,
        input  sample_l, sample_r, sample_valid, mix_phase
    );

    modport slave (
        input  ch1_out, ch2_out, ch3_out, ch4_out, ch_dac_en, vin,
        input  vin_l_ena, vin_r_ena, lmixer, rmixer, nlvolume, nrvolume,
        output sample_l, sample_r, sample_valid, mix_phase
    );

endinterface

// File: rtl/apu_mixer_lane.sv
// One stereo side of the mixer: pan-gated accumulation of the per-phase source,
// master-volume scaling and the held output sample.
module apu_mixer_lane
    import apu_mixer_pkg::*;
#(
    parameter int OUT_W = 11
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    active,
    input  mix_phase_t              phase,
    input  logic signed [5:0]       src,
    input  logic                    pan,
    input  logic [2:0]              nvol,
    output logic signed [OUT_W-1:0] sample
);

    logic signed [7:0]       acc_r;
    logic signed [OUT_W-1:0] prod_r;
    logic signed [OUT_W-1:0] sample_r;
    logic [3:0]              mult_u_s;
    logic signed [OUT_W-1:0] acc_ext_s;
    logic signed [OUT_W-1:0] mult_s;
    logic signed [OUT_W-1:0] scaled_s;

    // Volume multiplier (inverted code + 1, range 1..8) and exact signed product.
    always_comb begin
        mult_u_s  = {1'b0, ~nvol} + 4'd1;
        acc_ext_s = {{(OUT_W-8){acc_r[7]}}, acc_r};
        mult_s    = {{(OUT_W-4){1'b0}}, mult_u_s};
        scaled_s  = acc_ext_s * mult_s;
    end

    // Per-phase accumulate / scale / present sequence.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_r    <= 8'sd0;
            prod_r   <= {OUT_W{1'b0}};
            sample_r <= {OUT_W{1'b0}};
        end else if (active) begin
            case (phase)
                PH_LATCH: acc_r <= 8'sd0;
                PH_CH1, PH_CH2, PH_CH3, PH_CH4, PH_VIN: begin
                    if (pan) begin
                        acc_r <= acc_r + {{2{src[5]}}, src};
                    end else begin
                        acc_r <= acc_r;
                    end
                end
                PH_SCALE: prod_r   <= scaled_s;
                PH_OUT:   sample_r <= prod_r;
                default:  acc_r    <= acc_r;
            endcase
        end else begin
            acc_r <= acc_r;
        end
    end

    assign sample = sample_r;

endmodule

// File: rtl/apu_mixer.sv
// Time-multiplexed stereo mixer: snapshots channel/VIN codes and NR50/NR51 state
// once per sample period and drives two lanes that produce the L/R sample pair.
module apu_mixer
    import apu_mixer_pkg::*;
#(
    parameter int SAMPLE_DIV = 8,
    parameter int CODE_W     = 4,
    parameter int OUT_W      = 11
) (
    input  logic       apuv_4mhz,
    input  logic       napu_reset,
    apu_mixer_if.slave bus
);

    localparam int CNT_W = (SAMPLE_DIV > 8) ? $clog2(SAMPLE_DIV) : 3;

    logic [CNT_W-1:0]  cnt_r;
    logic [CNT_W-1:0]  cnt_nx_s;
    logic              active_nx_s;
    mix_phase_t        phase_nx_s;
    mix_phase_t        phase_r;
    logic              active_r;
    logic              valid_r;

    logic [CODE_W-1:0] ch_snap_r [4];
    logic [CODE_W-1:0] vin_snap_r;
    logic [3:0]        en_snap_r;
    logic [3:0]        lmix_snap_r;
    logic [3:0]        rmix_snap_r;
    logic              vin_l_snap_r;
    logic              vin_r_snap_r;
    logic [2:0]        nlvol_snap_r;
    logic [2:0]        nrvol_snap_r;

    logic signed [5:0] src_s;
    logic              pan_l_s;
    logic              pan_r_s;

    // Next phase; counts past 7 are idle and report PH_OUT on the debug port.
    always_comb begin
        if (cnt_r == CNT_W'(SAMPLE_DIV - 1)) begin
            cnt_nx_s = {CNT_W{1'b0}};
        end else begin
            cnt_nx_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end
        active_nx_s = ((cnt_nx_s >> 3) == {CNT_W{1'b0}});
        if (active_nx_s) begin
            phase_nx_s = mix_phase_t'(cnt_nx_s[2:0]);
        end else begin
            phase_nx_s = PH_OUT;
        end
    end

    // Phase sequencer and output strobe.
    always_ff @(posedge apuv_4mhz or negedge napu_reset) begin
        if (!napu_reset) begin
            cnt_r    <= {CNT_W{1'b0}};
            phase_r  <= PH_LATCH;
            active_r <= 1'b1;
            valid_r  <= 1'b0;
        end else begin
            cnt_r    <= cnt_nx_s;
            phase_r  <= phase_nx_s;
            active_r <= active_nx_s;
            valid_r  <= active_r && (phase_r == PH_OUT);
        end
    end

    // Frame snapshot: the rest of the frame sees only these copies.
    always_ff @(posedge apuv_4mhz or negedge napu_reset) begin
        if (!napu_reset) begin
            for (int i = 0; i < 4; i++) begin
                ch_snap_r[i] <= {CODE_W{1'b0}};
            end
            vin_snap_r   <= {CODE_W{1'b0}};
            en_snap_r    <= 4'd0;
            lmix_snap_r  <= 4'd0;
            rmix_snap_r  <= 4'd0;
            vin_l_snap_r <= 1'b0;
            vin_r_snap_r <= 1'b0;
            nlvol_snap_r <= 3'd0;
            nrvol_snap_r <= 3'd0;
        end else if (active_r && (phase_r == PH_LATCH)) begin
            ch_snap_r[0] <= bus.ch1_out;
            ch_snap_r[1] <= bus.ch2_out;
            ch_snap_r[2] <= bus.ch3_out;
            ch_snap_r[3] <= bus.ch4_out;
            vin_snap_r   <= bus.vin;
            en_snap_r    <= bus.ch_dac_en;
            lmix_snap_r  <= bus.lmixer;
            rmix_snap_r  <= bus.rmixer;
            vin_l_snap_r <= bus.vin_l_ena;
            vin_r_snap_r <= bus.vin_r_ena;
            nlvol_snap_r <= bus.nlvolume;
            nrvol_snap_r <= bus.nrvolume;
        end else begin
            vin_snap_r <= vin_snap_r;
        end
    end

    // Source selection for the current accumulate phase.
    always_comb begin
        src_s   = 6'sd0;
        pan_l_s = 1'b0;
        pan_r_s = 1'b0;
        case (phase_r)
            PH_CH1: begin
                src_s   = dac_signed(4'(ch_snap_r[0]), en_snap_r[0]);
                pan_l_s = lmix_snap_r[0];
                pan_r_s = rmix_snap_r[0];
            end
            PH_CH2: begin
                src_s   = dac_signed(4'(ch_snap_r[1]), en_snap_r[1]);
                pan_l_s = lmix_snap_r[1];
                pan_r_s = rmix_snap_r[1];
            end
            PH_CH3: begin
                src_s   = dac_signed(4'(ch_snap_r[2]), en_snap_r[2]);
                pan_l_s = lmix_snap_r[2];
                pan_r_s = rmix_snap_r[2];
            end
            PH_CH4: begin
                src_s   = dac_signed(4'(ch_snap_r[3]), en_snap_r[3]);
                pan_l_s = lmix_snap_r[3];
                pan_r_s = rmix_snap_r[3];
            end
            PH_VIN: begin
                src_s   = dac_signed(4'(vin_snap_r), 1'b1);
                pan_l_s = vin_l_snap_r;
                pan_r_s = vin_r_snap_r;
            end
            default: begin
                src_s   = 6'sd0;
                pan_l_s = 1'b0;
                pan_r_s = 1'b0;
            end
        endcase
    end

    apu_mixer_lane #(.OUT_W(OUT_W)) u_lane_l (
        .clk    (apuv_4mhz),
        .rst_n  (napu_reset),
        .active (active_r),
        .phase  (phase_r),
        .src    (src_s),
        .pan    (pan_l_s),
        .nvol   (nlvol_snap_r),
        .sample (bus.sample_l)
    );

    apu_mixer_lane #(.OUT_W(OUT_W)) u_lane_r (
        .clk    (apuv_4mhz),
        .rst_n  (napu_reset),
        .active (active_r),
        .phase  (phase_r),
        .src    (src_s),
        .pan    (pan_r_s),
        .nvol   (nrvol_snap_r),
        .sample (bus.sample_r)
    );

    assign bus.sample_valid = valid_r;
    assign bus.mix_phase    = phase_r;

endmodule

// File: tb/tb_apu_mixer.sv
// Scoreboard bench for apu_mixer: a frame-level arithmetic model queues the
// expected pair at each latch edge; a negedge monitor checks strobe, phase and samples.
module tb_apu_mixer;

    typedef struct {
        int l;
        int r;
    } pair_t;

    logic  clk;
    logic  rst_n;
    int    edge_cnt;
    int    checks;
    int    errors;
    int    last_l;
    int    last_r;
    pair_t exp_q[$];

    apu_mixer_if #(.CODE_W(4), .OUT_W(11)) bus ();

    apu_mixer #(.SAMPLE_DIV(8), .CODE_W(4), .OUT_W(11)) dut (
        .apuv_4mhz  (clk),
        .napu_reset (rst_n),
        .bus        (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // Reference: sum of enabled+panned levels (2*code-15) times (8 - inverted volume).
    function automatic int ref_side(input logic [3:0] pan, input logic vin_en, input logic [2:0] nvol);
        int codes[4];
        int sum;
        codes[0] = int'(bus.ch1_out);
        codes[1] = int'(bus.ch2_out);
        codes[2] = int'(bus.ch3_out);
        codes[3] = int'(bus.ch4_out);
        sum = 0;
        for (int i = 0; i < 4; i++) begin
            if (bus.ch_dac_en[i] && pan[i]) sum += 2 * codes[i] - 15;
        end
        if (vin_en) sum += 2 * int'(bus.vin) - 15;
        return sum * (8 - int'(nvol));
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) edge_cnt <= 0;
        else        edge_cnt <= edge_cnt + 1;
    end

    // Latch edges are edges 1, 9, 17, ... after reset release.
    always @(posedge clk) begin
        if (rst_n && (edge_cnt % 8 == 0)) begin
            pair_t p;
            p.l = ref_side(bus.lmixer, bus.vin_l_ena, bus.nlvolume);
            p.r = ref_side(bus.rmixer, bus.vin_r_ena, bus.nrvolume);
            exp_q.push_back(p);
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_valid", int'(bus.sample_valid), 0);
            chk("rst_sample_l", int'(bus.sample_l), 0);
            chk("rst_sample_r", int'(bus.sample_r), 0);
            chk("rst_phase", int'(bus.mix_phase), 0);
            last_l = 0;
            last_r = 0;
        end else begin
            chk("valid", int'(bus.sample_valid), int'(edge_cnt > 0 && edge_cnt % 8 == 0));
            chk("phase", int'(bus.mix_phase), edge_cnt % 8);
            if (bus.sample_valid) begin
                chk("sb_has_entry", int'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    pair_t e;
                    e = exp_q.pop_front();
                    chk("sample_l", int'(bus.sample_l), e.l);
                    chk("sample_r", int'(bus.sample_r), e.r);
                    last_l = e.l;
                    last_r = e.r;
                end
            end else begin
                chk("hold_l", int'(bus.sample_l), last_l);
                chk("hold_r", int'(bus.sample_r), last_r);
            end
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] c1, input logic [3:0] c2, input logic [3:0] c3,
                         input logic [3:0] c4, input logic [3:0] en, input logic [3:0] v,
                         input logic vl, input logic vr, input logic [3:0] lm,
                         input logic [3:0] rm, input logic [2:0] nl, input logic [2:0] nr);
        bus.ch1_out   = c1;
        bus.ch2_out   = c2;
        bus.ch3_out   = c3;
        bus.ch4_out   = c4;
        bus.ch_dac_en = en;
        bus.vin       = v;
        bus.vin_l_ena = vl;
        bus.vin_r_ena = vr;
        bus.lmixer    = lm;
        bus.rmixer    = rm;
        bus.nlvolume  = nl;
        bus.nrvolume  = nr;
    endtask

    task automatic rand_inputs();
        drive(4'($urandom_range(15, 0)), 4'($urandom_range(15, 0)), 4'($urandom_range(15, 0)),
              4'($urandom_range(15, 0)), 4'($urandom_range(15, 0)), 4'($urandom_range(15, 0)),
              1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)), 4'($urandom_range(15, 0)),
              4'($urandom_range(15, 0)), 3'($urandom_range(7, 0)), 3'($urandom_range(7, 0)));
    endtask

    task automatic frame_check(input string name, input int exp_l, input int exp_r);
        repeat (8) step();
        chk({name, "_l"}, int'(bus.sample_l), exp_l);
        chk({name, "_r"}, int'(bus.sample_r), exp_r);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        last_l = 0;
        last_r = 0;
        rst_n  = 1'b0;
        drive(4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 4'd0, 3'd0, 3'd0);

        repeat (3) step();
        rst_n = 1'b1;

        // Single channel, left only, full volume.
        drive(4'd15, 4'd0, 4'd0, 4'd0, 4'b0001, 4'd0, 1'b0, 1'b0, 4'b0001, 4'b0000, 3'd0, 3'd0);
        frame_check("t2_ch1_left", 120, 0);

        // All sources at code 0 on both sides, minimum volume.
        drive(4'd0, 4'd0, 4'd0, 4'd0, 4'b1111, 4'd0, 1'b1, 1'b1, 4'b1111, 4'b1111, 3'd7, 3'd7);
        frame_check("t3_all_min", -75, -75);

        // Panned channel with its DAC unpowered.
        drive(4'd0, 4'd15, 4'd0, 4'd0, 4'b0000, 4'd0, 1'b0, 1'b0, 4'b0010, 4'b0010, 3'd0, 3'd0);
        frame_check("t4_dac_off", 0, 0);

        // Pan change mid-frame only affects the following frame.
        drive(4'd15, 4'd0, 4'd0, 4'd0, 4'b0001, 4'd0, 1'b0, 1'b0, 4'b0001, 4'b0000, 3'd7, 3'd7);
        repeat (3) step();
        bus.lmixer = 4'b0000;
        repeat (5) step();
        chk("t5_cur_l", int'(bus.sample_l), 15);
        frame_check("t5_next", 0, 0);

        for (int i = 0; i < 480; i++) begin
            rand_inputs();
            step();
        end

        // Reset in the VIN phase aborts the frame.
        for (int i = 0; i < 16 && (edge_cnt % 8 != 5); i++) step();
        chk("t6_reach_p5", edge_cnt % 8, 5);
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        chk("t6_rst_l", int'(bus.sample_l), 0);
        chk("t6_rst_r", int'(bus.sample_r), 0);
        chk("t6_rst_valid", int'(bus.sample_valid), 0);
        repeat (2) step();
        rst_n = 1'b1;

        for (int i = 0; i < 80; i++) begin
            rand_inputs();
            step();
        end
        chk("sb_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
